// File: rtl/vce_capture.sv
// vce_capture: samples the VCE pixel stream on clock_en, tracks sync timing and
// emits one registered frame-buffer write per active pixel (RGB333, linear addr).
module vce_capture #(
  parameter int H_START  = 40,
  parameter int H_ACTIVE = 256,
  parameter int V_START  = 14,
  parameter int V_ACTIVE = 240
) (
  input  logic        clock,
  input  logic        reset_N,
  input  logic        clock_en,
  input  logic [2:0]  VIDEO_R,
  input  logic [2:0]  VIDEO_G,
  input  logic [2:0]  VIDEO_B,
  input  logic        HSYNC_n,
  input  logic        VSYNC_n,
  output logic        pix_we,
  output logic [15:0] pix_addr,
  output logic [8:0]  pix_data,
  output logic        frame_start,
  output logic        frame_done,
  output logic        line_short,
  output logic [7:0]  frame_cnt
);

  localparam logic [2:0] S_SEEK   = 3'd0;
  localparam logic [2:0] S_VBLANK = 3'd1;
  localparam logic [2:0] S_HWAIT  = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_HDONE  = 3'd4;
  localparam logic [2:0] S_VDONE  = 3'd5;

  localparam logic [15:0] HS16 = 16'(H_START);
  localparam logic [15:0] HA16 = 16'(H_ACTIVE);
  localparam logic [15:0] VS16 = 16'(V_START);
  localparam logic [15:0] VA16 = 16'(V_ACTIVE);

  logic [2:0]  state;
  logic        hs_q, vs_q;   // sync history, advanced only on pixel strobes
  logic [15:0] x, y;
  logic [15:0] cnt;          // HSYNC edges in VBLANK, pixel delay in HWAIT
  logic        hs_fall, vs_fall, last_y;
  logic [15:0] addr_c;

  assign hs_fall = clock_en & hs_q & ~HSYNC_n;
  assign vs_fall = clock_en & vs_q & ~VSYNC_n;
  assign last_y  = (y == VA16 - 16'd1);
  assign addr_c  = y * HA16 + x;

  // Capture FSM, counters and registered write port; pulses self-clear each clock.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state       <= S_SEEK;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      x           <= '0;
      y           <= '0;
      cnt         <= '0;
      pix_we      <= 1'b0;
      pix_addr    <= '0;
      pix_data    <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      line_short  <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      pix_we      <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      line_short  <= 1'b0;
      if (clock_en) begin
        hs_q <= HSYNC_n;
        vs_q <= VSYNC_n;
        if (vs_fall) begin
          // VSYNC wins over a coincident HSYNC edge, which is then not counted
          frame_start <= 1'b1;
          x     <= '0;
          y     <= '0;
          cnt   <= '0;
          state <= S_VBLANK;
        end else begin
          case (state)
            S_VBLANK: if (hs_fall) begin
              if (cnt == VS16 - 16'd1) begin
                state <= S_HWAIT;
                cnt   <= '0;
              end else begin
                cnt <= cnt + 16'd1;
              end
            end
            S_HWAIT: begin
              if (hs_fall) begin
                cnt <= '0;                         // restart delay, same line
              end else if (cnt == HS16 - 16'd1) begin
                state <= S_ACTIVE;                 // this strobe is not captured
                cnt   <= '0;
                x     <= '0;
              end else begin
                cnt <= cnt + 16'd1;
              end
            end
            S_ACTIVE: begin
              if (hs_fall) begin
                // line cut short: drop the rest and move to the next line
                line_short <= 1'b1;
                x   <= '0;
                cnt <= '0;
                if (last_y) begin
                  state <= S_VDONE;
                end else begin
                  y     <= y + 16'd1;
                  state <= S_HWAIT;
                end
              end else begin
                pix_we   <= 1'b1;
                pix_addr <= addr_c;
                pix_data <= {VIDEO_R, VIDEO_G, VIDEO_B};
                if (x == HA16 - 16'd1) begin
                  state <= S_HDONE;
                  if (last_y) begin
                    frame_done <= 1'b1;
                    frame_cnt  <= frame_cnt + 8'd1;
                  end
                end else begin
                  x <= x + 16'd1;
                end
              end
            end
            S_HDONE: if (hs_fall) begin
              x   <= '0;
              cnt <= '0;
              if (last_y) begin
                state <= S_VDONE;
              end else begin
                y     <= y + 16'd1;
                state <= S_HWAIT;
              end
            end
            S_SEEK, S_VDONE: ;                     // only a VSYNC edge leaves
            default: state <= S_SEEK;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_vce_capture.sv
// tb_vce_capture: randomized sync/colour stream with a ce-count based reference model.
module tb_vce_capture;
  localparam int HS = 3, HA = 8, VS = 2, VA = 4;

  logic        clock = 1'b0, reset_N = 1'b0, clock_en = 1'b0;
  logic [2:0]  VIDEO_R = '0, VIDEO_G = '0, VIDEO_B = '0;
  logic        HSYNC_n = 1'b1, VSYNC_n = 1'b1;
  logic        pix_we, frame_start, frame_done, line_short;
  logic [15:0] pix_addr;
  logic [8:0]  pix_data;
  logic [7:0]  frame_cnt;

  vce_capture #(.H_START(HS), .H_ACTIVE(HA), .V_START(VS), .V_ACTIVE(VA)) dut (
    .clock(clock), .reset_N(reset_N), .clock_en(clock_en),
    .VIDEO_R(VIDEO_R), .VIDEO_G(VIDEO_G), .VIDEO_B(VIDEO_B),
    .HSYNC_n(HSYNC_n), .VSYNC_n(VSYNC_n),
    .pix_we(pix_we), .pix_addr(pix_addr), .pix_data(pix_data),
    .frame_start(frame_start), .frame_done(frame_done),
    .line_short(line_short), .frame_cnt(frame_cnt));

  always #5 clock = ~clock;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model: phase since VSYNC and strobe count k since the last HSYNC edge.
  // mode 0 = waiting for VSYNC, 1 = counting blank lines, 2 = in picture, 3 = frame over
  int m_mode, m_edges, m_y, m_k;
  logic m_phs, m_pvs;
  logic e_we, e_fs, e_fd, e_ls;
  logic [15:0] e_addr;
  logic [8:0]  e_data;
  logic [7:0]  e_fc;

  int idle_max = 2;
  int nwe = 0, nfd = 0, first_addr = -1, last_addr = -1;

  task automatic model_reset();
    m_mode = 0; m_edges = 0; m_y = 0; m_k = 0; m_phs = 1'b1; m_pvs = 1'b1;
    e_we = 0; e_fs = 0; e_fd = 0; e_ls = 0; e_addr = '0; e_data = '0; e_fc = '0;
  endtask

  task automatic model_ce(input logic hs, input logic vs, input logic [8:0] d);
    bit hf, vf;
    hf = m_phs && !hs;
    vf = m_pvs && !vs;
    m_phs = hs; m_pvs = vs;
    e_we = 0; e_fs = 0; e_fd = 0; e_ls = 0;
    if (vf) begin
      e_fs = 1; m_mode = 1; m_edges = 0; m_y = 0;
    end else if (m_mode == 1) begin
      if (hf) begin
        m_edges++;
        if (m_edges == VS) begin m_mode = 2; m_k = 0; end
      end
    end else if (m_mode == 2) begin
      if (hf) begin
        if (m_k < HS) m_k = 0;                      // still in delay: restart
        else begin
          if (m_k < HS + HA) e_ls = 1;              // fewer than HA pixels taken
          if (m_y == VA - 1) m_mode = 3;
          else begin m_y++; m_k = 0; end
        end
      end else begin
        m_k++;
        if (m_k > HS && m_k <= HS + HA) begin
          e_we = 1;
          e_addr = 16'(m_y * HA + (m_k - HS - 1));
          e_data = d;
          if (m_k == HS + HA && m_y == VA - 1) begin e_fd = 1; e_fc = e_fc + 8'd1; end
        end
      end
    end
  endtask

  task automatic tick(input logic ce, input logic hs, input logic vs);
    logic [2:0] rr, gg, bb;
    rr = 3'($urandom); gg = 3'($urandom); bb = 3'($urandom);
    clock_en = ce; HSYNC_n = hs; VSYNC_n = vs;
    VIDEO_R = rr; VIDEO_G = gg; VIDEO_B = bb;
    if (ce) model_ce(hs, vs, {rr, gg, bb});
    else begin e_we = 0; e_fs = 0; e_fd = 0; e_ls = 0; end
    @(posedge clock);
    @(negedge clock);
    if (pix_we) begin
      if (nwe == 0) first_addr = int'(pix_addr);
      last_addr = int'(pix_addr);
      nwe++;
    end
    if (frame_done) nfd++;
    chk("outs", {27'd0, pix_we, pix_addr, pix_data, frame_start, frame_done, line_short, frame_cnt},
                {27'd0, e_we, e_addr, e_data, e_fs, e_fd, e_ls, e_fc});
  endtask

  // One pixel strobe followed by idle clocks where syncs wiggle but must be ignored.
  task automatic pce(input logic hs, input logic vs);
    tick(1'b1, hs, vs);
    repeat ($urandom_range(idle_max, 0)) tick(1'b0, 1'($urandom), 1'($urandom));
  endtask

  task automatic hline(input int len);
    pce(1'b0, 1'b1);
    repeat (len - 1) pce(1'b1, 1'b1);
  endtask

  task automatic vsync(input bit co);
    pce(co ? 1'b0 : 1'b1, 1'b0);
    pce(1'b1, 1'b1);
    pce(1'b1, 1'b1);
  endtask

  function automatic int normal_len();
    return HS + HA + 1 + int'($urandom_range(3, 0));
  endfunction

  // Clean frame: blanking, VA full lines, then two spare lines into VDONE.
  task automatic full_frame(input bit co);
    vsync(co);
    repeat (VS + VA + 1) hline(normal_len());
  endtask

  // Line lengths mixed among full, short (line_short) and delay restarts; may end early.
  task automatic rand_frame();
    int nl, kind;
    vsync(1'($urandom));
    nl = int'($urandom_range(VS + VA + 1, 1));
    for (int i = 0; i < nl; i++) begin
      kind = int'($urandom_range(9, 0));
      if (kind < 6)      hline(normal_len());
      else if (kind < 9) hline(HS + 1 + int'($urandom_range(HA - 1, 0)));
      else               hline(int'($urandom_range(HS, 1)));
    end
  endtask

  int n0, f0;

  initial begin
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_state", {27'd0, pix_we, pix_addr, pix_data, frame_start, frame_done, line_short, frame_cnt}, 64'd0);
    reset_N = 1'b1;

    // clean frame with sparse strobes
    idle_max = 3;
    full_frame(1'b0);
    chk("frame_writes", 64'(nwe), 64'(VA * HA));
    chk("first_addr", 64'(first_addr), 64'd0);
    chk("last_addr", 64'(last_addr), 64'(VA * HA - 1));
    chk("frame_done_cnt", 64'(nfd), 64'd1);
    chk("frame_cnt_1", 64'(frame_cnt), 64'd1);

    // coincident HSYNC/VSYNC edge: still VS further edges to the first line
    n0 = nwe;
    full_frame(1'b1);
    chk("coinc_writes", 64'(nwe - n0), 64'(VA * HA));
    chk("frame_cnt_2", 64'(frame_cnt), 64'd2);

    // random mixes of short lines, delay restarts and early VSYNC
    idle_max = 2;
    repeat (12) rand_frame();

    // async reset in the middle of an active line
    vsync(1'b0);
    repeat (VS) hline(normal_len());
    pce(1'b0, 1'b1);
    repeat (HS + 3) pce(1'b1, 1'b1);
    #2 reset_N = 1'b0;
    #1 chk("async_reset", {27'd0, pix_we, pix_addr, pix_data, frame_start, frame_done, line_short, frame_cnt}, 64'd0);
    @(posedge clock);
    @(negedge clock);
    reset_N = 1'b1;
    model_reset();
    n0 = nwe;
    repeat (4) hline(normal_len());
    chk("no_we_after_reset", 64'(nwe - n0), 64'd0);

    // 256 complete frames wrap the frame counter back to 0
    idle_max = 0;
    f0 = nfd;
    repeat (256) full_frame(1'($urandom));
    chk("wrap_done_cnt", 64'(nfd - f0), 64'd256);
    chk("frame_cnt_wrap", 64'(frame_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vce_capture.md
VCE_CAPTURE -- requirements
Module: vce_capture

Interface
REQ-001 Parameter H_START, default 40: clock_en pixels from HSYNC_n falling edge to first captured pixel.
REQ-002 Parameter H_ACTIVE, default 256: pixels captured per line.
REQ-003 Parameter V_START, default 14: HSYNC_n falling edges after VSYNC_n falling edge before first captured line.
REQ-004 Parameter V_ACTIVE, default 240: lines captured per frame.
REQ-005 clock  input  1  system clock; all state changes on rising edge.
REQ-006 reset_N  input  1  asynchronous, active-low reset.
REQ-007 clock_en  input  1  VCE pixel strobe; inputs below are sampled only when high.
REQ-008 VIDEO_R, VIDEO_G, VIDEO_B  input  3 each  VCE colour components.
REQ-009 HSYNC_n, VSYNC_n  input  1 each  VCE/VDC active-low syncs.
REQ-010 pix_we  output  1  one-clock write strobe to frame buffer.
REQ-011 pix_addr  output  16  linear address y*H_ACTIVE + x.
REQ-012 pix_data  output  9  {R,G,B} RGB333.
REQ-013 frame_start  output  1  one-clock pulse on accepted VSYNC_n falling edge.
REQ-014 frame_done  output  1  one-clock pulse after last pixel of line V_ACTIVE-1 is written.
REQ-015 line_short  output  1  one-clock pulse when a line ends before H_ACTIVE pixels.
REQ-016 frame_cnt  output  8  count of completed frames, wraps 255->0.

Function
REQ-017 Sync edges SHALL be detected against registers of HSYNC_n/VSYNC_n updated only on clock_en cycles; a falling edge is prev=1, cur=0 on a clock_en cycle.
REQ-018 States: SEEK, VBLANK, HWAIT, ACTIVE, HDONE, VDONE.
REQ-019 SEEK: ignore everything until a VSYNC_n falling edge, then go to VBLANK.
REQ-020 On any VSYNC_n falling edge, in any state: pulse frame_start, clear line counter y and pixel counter x, enter VBLANK.
REQ-021 VBLANK: count HSYNC_n falling edges; on edge number V_START, enter HWAIT with pixel-delay counter 0.
REQ-022 HWAIT: count clock_en cycles; on the H_START-th cycle after the HSYNC edge, enter ACTIVE; that cycle is not itself captured.
REQ-023 ACTIVE: each clock_en cycle captures one pixel at x, then x increments; after x reaches H_ACTIVE-1 and is captured, enter HDONE.
REQ-024 pix_we, pix_addr and pix_data SHALL be registered, asserted exactly one clock after the capturing clock_en cycle, holding that cycle's colour and address.
REQ-025 HDONE: on HSYNC_n falling edge, y increments, x clears; if y was V_ACTIVE-1, enter VDONE instead of HWAIT.
REQ-026 frame_done and frame_cnt increment occur in the same clock as the final pix_we.
REQ-027 HSYNC_n falling edge in ACTIVE with x < H_ACTIVE: pulse line_short, stop the line (no further writes), advance y as in REQ-025, enter HWAIT or VDONE.
REQ-028 HSYNC_n falling edge in HWAIT: restart the H_START delay, y unchanged.
REQ-029 VDONE: no writes; wait for VSYNC_n falling edge (REQ-020).
REQ-030 Simultaneous HSYNC_n and VSYNC_n falling edges: VSYNC_n wins; the HSYNC_n edge is not counted toward V_START.
REQ-031 VSYNC_n falling edge before frame completion: no frame_done, frame_cnt unchanged, writes already issued remain.
REQ-032 No output changes on cycles with clock_en low, except the one-clock deassertion of pulses.
REQ-033 Address arithmetic SHALL be 16-bit; pix_addr never exceeds H_ACTIVE*V_ACTIVE-1.

Reset
REQ-034 reset_N low asynchronously forces state SEEK, all counters 0, sync history registers 1, and pix_we, pix_addr, pix_data, frame_start, frame_done, line_short, frame_cnt to 0.
REQ-035 Reset released mid-line SHALL produce no writes until the next VSYNC_n falling edge.

Verification
REQ-036 Full frame (default params, clock_en every 4th clock): exactly 61440 pix_we; first pix_addr 0, last 61439; one frame_done; frame_cnt 0->1.
REQ-037 Constant colour R=5,G=2,B=7 during first captured line: pix_data 9'b101_010_111 at addresses 0..255, each one clock after its clock_en.
REQ-038 HSYNC_n falls after 100 active pixels on line 3: line_short pulses once; addresses 768..867 written; line 4 begins at 1024.
REQ-039 VSYNC_n falls at line 120: frame_start pulses, no frame_done, frame_cnt unchanged; next frame starts at address 0.
REQ-040 HSYNC_n and VSYNC_n fall on same clock_en: first captured line follows V_START further HSYNC_n edges, not V_START-1.
REQ-041 reset_N pulsed low during ACTIVE: outputs 0 immediately; no pix_we before next VSYNC_n edge; 256 frames -> frame_cnt wraps to 0.
